proc_mem_responder: RTL and testbench

Memory-side responder for the TinyRV1 processor's instruction and data memory request interfaces. It accepts one fetch request and one data request per cycle with no backpressure, services them against a shared word-addressed storage array, and returns responses through a fixed-latency valid pipeline. It sits opposite the processor in the top-level test harness and in the FPGA top. It also provides a backdoor load port for program images and a sticky error flag for illegal addresses.

---
 rtl/proc_mem_responder.sv | 126 ++++++++++++
 tb/tb_proc_mem_responder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_responder.sv
// Memory-side responder for TinyRV1 fetch and data ports over one shared word array.
// Latency: LATENCY cycles from request edge to response, per port, full throughput.
// Backpressure: none; every valid request is accepted on the edge that samples it.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   imemreq_val/_addr            fetch request (byte address)
//   imemresp_val/_data           fetch response, LATENCY cycles later
//   dmemreq_val/_type/_addr/_wdata  data request (type 0 = read, 1 = write)
//   dmemresp_val/_rdata          data response; rdata is 0 for writes
//   load_en/_addr/_data          backdoor image load, honoured even during rst
//   err                          sticky flag for any illegal address, cleared by rst
module proc_mem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_data,

    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_rdata,

    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,

    output logic        err
);

    localparam int AW = $clog2(WORDS);

    // Word aligned and inside the array; everything above the index bits must be zero.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    logic [31:0] mem [WORDS];

    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic [AW-1:0] ld_idx;
    logic          i_legal;
    logic          d_legal;
    logic          ld_legal;
    logic          d_wr;
    logic          any_bad;

    assign i_idx    = imemreq_addr[2 +: AW];
    assign d_idx    = dmemreq_addr[2 +: AW];
    assign ld_idx   = load_addr[2 +: AW];
    assign i_legal  = addr_ok(imemreq_addr);
    assign d_legal  = addr_ok(dmemreq_addr);
    assign ld_legal = addr_ok(load_addr);
    assign d_wr     = !rst && dmemreq_val && dmemreq_type && d_legal;

    assign any_bad = (imemreq_val && !i_legal)
                  || (dmemreq_val && !d_legal)
                  || (load_en && !ld_legal);

    // Array writes. The load port is written last so it wins over a data-port
    // write to the same word. Loads are accepted regardless of rst so images
    // can be written while the core is held in reset. No reset on the array.
    always_ff @(posedge clk) begin
        if (d_wr) begin
            mem[d_idx] <= dmemreq_wdata;
        end
        if (load_en && ld_legal) begin
            mem[ld_idx] <= load_data;
        end
    end

    // Response pipelines. Stage 0 captures the array with non-blocking
    // semantics, so reads always see pre-edge contents even when a write to
    // the same word commits on that edge.
    logic        i_vld_q [LATENCY];
    logic [31:0] i_dat_q [LATENCY];
    logic        d_vld_q [LATENCY];
    logic [31:0] d_dat_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                i_vld_q[s] <= 1'b0;
                i_dat_q[s] <= '0;
                d_vld_q[s] <= 1'b0;
                d_dat_q[s] <= '0;
            end
        end else begin
            i_vld_q[0] <= imemreq_val;
            i_dat_q[0] <= (imemreq_val && i_legal) ? mem[i_idx] : '0;
            d_vld_q[0] <= dmemreq_val;
            // Writes and illegal reads both return zero data.
            d_dat_q[0] <= (dmemreq_val && !dmemreq_type && d_legal) ? mem[d_idx] : '0;
            for (int s = 1; s < LATENCY; s++) begin
                i_vld_q[s] <= i_vld_q[s-1];
                i_dat_q[s] <= i_dat_q[s-1];
                d_vld_q[s] <= d_vld_q[s-1];
                d_dat_q[s] <= d_dat_q[s-1];
            end
        end
    end

    // Sticky error; rst takes priority over a simultaneous illegal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (any_bad) begin
            err <= 1'b1;
        end
    end

    assign imemresp_val   = i_vld_q[LATENCY-1];
    assign imemresp_data  = i_dat_q[LATENCY-1];
    assign dmemresp_val   = d_vld_q[LATENCY-1];
    assign dmemresp_rdata = d_dat_q[LATENCY-1];

endmodule

// File: tb/tb_proc_mem_responder.sv
module tb_proc_mem_responder;

    localparam int HIST = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    // Three DUTs share the stimulus: index 0 has LATENCY=1, 1 has 3, 2 has 2.
    logic [2:0]  iv;
    logic [2:0]  dv;
    logic [2:0]  er;
    logic [31:0] id [3];
    logic [31:0] dd [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            proc_mem_responder #(
                .WORDS   (256),
                .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 2))
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .imemreq_val    (imemreq_val),
                .imemreq_addr   (imemreq_addr),
                .imemresp_val   (iv[g]),
                .imemresp_data  (id[g]),
                .dmemreq_val    (dmemreq_val),
                .dmemreq_type   (dmemreq_type),
                .dmemreq_addr   (dmemreq_addr),
                .dmemreq_wdata  (dmemreq_wdata),
                .dmemresp_val   (dv[g]),
                .dmemresp_rdata (dd[g]),
                .load_en        (load_en),
                .load_addr      (load_addr),
                .load_data      (load_data),
                .err            (er[g])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    logic [31:0] mm [256];
    logic        hi_v [HIST];
    logic [31:0] hi_d [HIST];
    logic        hd_v [HIST];
    logic [31:0] hd_d [HIST];
    int          edge_no  = 0;
    int          last_rst = -1;
    logic        err_m    = 1'b0;
    logic        ev_i [3];
    logic [31:0] ed_i [3];
    logic        ev_d [3];
    logic [31:0] ed_d [3];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return ((a % 4) == 0) && (a < 32'd1024);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    // Applies the behaviour of one rising edge to the model: reads see the
    // pre-edge array, then the data write, then the load write.
    task automatic model_edge();
        int e;
        int n;
        e = edge_no;
        hi_v[e] = imemreq_val && !rst;
        hi_d[e] = legal(imemreq_addr) ? mm[widx(imemreq_addr)] : 32'h0;
        hd_v[e] = dmemreq_val && !rst;
        hd_d[e] = (!dmemreq_type && legal(dmemreq_addr)) ? mm[widx(dmemreq_addr)] : 32'h0;
        if (rst) begin
            err_m    = 1'b0;
            last_rst = e;
        end else if ((imemreq_val && !legal(imemreq_addr)) ||
                     (dmemreq_val && !legal(dmemreq_addr)) ||
                     (load_en && !legal(load_addr))) begin
            err_m = 1'b1;
        end
        if (!rst && dmemreq_val && dmemreq_type && legal(dmemreq_addr))
            mm[widx(dmemreq_addr)] = dmemreq_wdata;
        if (load_en && legal(load_addr))
            mm[widx(load_addr)] = load_data;
        // A response shows after edge e for the request taken at edge e-L+1,
        // unless a reset edge has occurred since (inclusive).
        for (int k = 0; k < 3; k++) begin
            n = e - lat_of(k) + 1;
            if (n >= 0 && n > last_rst) begin
                ev_i[k] = hi_v[n];
                ed_i[k] = hi_d[n];
                ev_d[k] = hd_v[n];
                ed_d[k] = hd_d[n];
            end else begin
                ev_i[k] = 1'b0;
                ed_i[k] = 32'h0;
                ev_d[k] = 1'b0;
                ed_d[k] = 32'h0;
            end
        end
        if (edge_no < HIST - 1) edge_no++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        imemreq_val  = 1'b0;
        dmemreq_val  = 1'b0;
        dmemreq_type = 1'b0;
        load_en      = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst     = 1'b1;
        load_en = 1'b1;
        for (int w = 0; w < 256; w++) begin
            load_addr = 32'(w * 4);
            load_data = $urandom;
            tick();
            if (w < 3 || w == 255) begin
                n_vec++;
                if ({iv, dv, er} !== 9'b0) begin
                    n_fail++;
                    $display("FAIL reset_vals w%0d: got iv=%b dv=%b err=%b, want all 0", w, iv, dv, er);
                end
                for (int k = 0; k < 3; k++) begin
                    n_vec++;
                    if (id[k] !== 32'h0 || dd[k] !== 32'h0) begin
                        n_fail++;
                        $display("FAIL reset_data dut%0d: got %h/%h, want 0/0", k, id[k], dd[k]);
                    end
                end
            end
        end
        load_en = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_load_fetch();
        load_en = 1'b1; load_addr = 32'h0; load_data = 32'h0000_0013; tick();
        load_addr = 32'h4; load_data = 32'hDEAD_BEEF; tick();
        load_en = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h0; tick();
        n_vec++;
        if (iv[0] !== 1'b1 || id[0] !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL lf_first: got val=%b data=%h, want 1/00000013", iv[0], id[0]);
        end
        imemreq_addr = 32'h4; tick();
        n_vec++;
        if (iv[0] !== 1'b1 || id[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lf_second: got val=%b data=%h, want 1/deadbeef", iv[0], id[0]);
        end
        idle(); tick();
        n_vec++;
        if (iv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lf_end: got val=%b, want 0", iv[0]);
        end
    endtask

    task automatic test_fwd();
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'h1111_1111; tick();
        load_en = 1'b0;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h10; dmemreq_wdata = 32'h1234_5678;
        imemreq_val = 1'b1; imemreq_addr = 32'h10;
        tick();
        n_vec++;
        if (iv[0] !== 1'b1 || id[0] !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL fw_fetch_old: got val=%b data=%h, want 1/11111111", iv[0], id[0]);
        end
        n_vec++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL fw_wresp: got val=%b data=%h, want 1/00000000", dv[0], dd[0]);
        end
        imemreq_val = 1'b0; dmemreq_type = 1'b0; tick();
        n_vec++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL fw_read: got val=%b data=%h, want 1/12345678", dv[0], dd[0]);
        end
        idle(); tick();
    endtask

    task automatic test_latency();
        logic [31:0] lv [4];
        logic        exp_v;
        load_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            lv[j] = $urandom;
            load_addr = 32'(32'h40 + 4 * j);
            load_data = lv[j];
            tick();
        end
        load_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            dmemreq_val  = (j < 4);
            dmemreq_type = 1'b0;
            dmemreq_addr = 32'(32'h40 + 4 * j);
            tick();
            exp_v = (j >= 2 && j <= 5);
            n_vec++;
            if (dv[1] !== exp_v) begin
                n_fail++;
                $display("FAIL lat3_val step%0d: got %b, want %b", j, dv[1], exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if (dd[1] !== lv[j-2]) begin
                    n_fail++;
                    $display("FAIL lat3_data step%0d: got %h, want %h", j, dd[1], lv[j-2]);
                end
            end
        end
        idle();
    endtask

    task automatic test_illegal();
        rst = 1'b1; tick(); rst = 1'b0;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h2; dmemreq_wdata = 32'hFFFF_FFFF;
        tick();
        n_vec++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'h0 || er[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_wresp: got val=%b data=%h err=%b, want 1/0/1", dv[0], dd[0], er[0]);
        end
        dmemreq_type = 1'b0; dmemreq_addr = 32'd1024; tick();
        n_vec++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL ill_rresp: got val=%b data=%h, want 1/00000000", dv[0], dd[0]);
        end
        dmemreq_addr = 32'h0; tick();
        n_vec++;
        if (dd[0] !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL ill_array: got %h, want 00000013", dd[0]);
        end
        idle();
        for (int j = 0; j < 3; j++) tick();
        n_vec++;
        if (er !== 3'b111) begin
            n_fail++;
            $display("FAIL ill_sticky: got err=%b, want 111", er);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++;
        if (er !== 3'b000) begin
            n_fail++;
            $display("FAIL ill_clear: got err=%b, want 000", er);
        end
    endtask

    task automatic test_reset_mid();
        dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h4; tick();
        n_vec++;
        if (dv[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_early: got val=%b, want 0", dv[2]);
        end
        rst = 1'b1;
        dmemreq_type = 1'b1; dmemreq_wdata = 32'h9999_9999;
        imemreq_val = 1'b1; imemreq_addr = 32'h0;
        tick();
        n_vec++;
        if ({iv, dv, er} !== 9'b0 || dd[2] !== 32'h0 || dd[0] !== 32'h0 || id[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_clear: got iv=%b dv=%b err=%b dd2=%h, want all 0", iv, dv, er, dd[2]);
        end
        idle(); tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_vec++;
            if ({iv, dv} !== 6'b0) begin
                n_fail++;
                $display("FAIL rm_nodrop step%0d: got iv=%b dv=%b, want 0", j, iv, dv);
            end
        end
        dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h4; tick();
        n_vec++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rm_retain: got val=%b data=%h, want 1/deadbeef", dv[0], dd[0]);
        end
        idle(); tick();
    endtask

    task automatic test_load_priority();
        load_en = 1'b1; load_addr = 32'h20; load_data = 32'hAAAA_0000;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h20; dmemreq_wdata = 32'h5555_FFFF;
        tick();
        load_en = 1'b0; dmemreq_type = 1'b0; tick();
        n_vec++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL lp_read: got val=%b data=%h, want 1/aaaa0000", dv[0], dd[0]);
        end
        idle(); tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom % 16;
        if (r == 0) return $urandom;
        if (r == 1) return 32'(($urandom % 256) * 4 + ($urandom % 3) + 1);
        return 32'(($urandom % 256) * 4);
    endfunction

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst           = (($urandom % 40) == 0);
            imemreq_val   = 1'($urandom);
            imemreq_addr  = rand_addr();
            dmemreq_val   = 1'($urandom);
            dmemreq_type  = 1'($urandom);
            dmemreq_addr  = rand_addr();
            dmemreq_wdata = $urandom;
            load_en       = (($urandom % 4) == 0);
            load_addr     = rst ? 32'(($urandom % 256) * 4) : rand_addr();
            load_data     = $urandom;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (iv[k] !== ev_i[k]) begin
                    n_fail++;
                    $display("FAIL rnd_ival dut%0d cyc%0d: got %b, want %b", k, c, iv[k], ev_i[k]);
                end
                if (ev_i[k]) begin
                    n_vec++;
                    if (id[k] !== ed_i[k]) begin
                        n_fail++;
                        $display("FAIL rnd_idata dut%0d cyc%0d: got %h, want %h", k, c, id[k], ed_i[k]);
                    end
                end
                n_vec++;
                if (dv[k] !== ev_d[k]) begin
                    n_fail++;
                    $display("FAIL rnd_dval dut%0d cyc%0d: got %b, want %b", k, c, dv[k], ev_d[k]);
                end
                if (ev_d[k]) begin
                    n_vec++;
                    if (dd[k] !== ed_d[k]) begin
                        n_fail++;
                        $display("FAIL rnd_ddata dut%0d cyc%0d: got %h, want %h", k, c, dd[k], ed_d[k]);
                    end
                end
                n_vec++;
                if (er[k] !== err_m) begin
                    n_fail++;
                    $display("FAIL rnd_err dut%0d cyc%0d: got %b, want %b", k, c, er[k], err_m);
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst           = 1'b1;
        imemreq_val   = 1'b0;
        imemreq_addr  = 32'h0;
        dmemreq_val   = 1'b0;
        dmemreq_type  = 1'b0;
        dmemreq_addr  = 32'h0;
        dmemreq_wdata = 32'h0;
        load_en       = 1'b0;
        load_addr     = 32'h0;
        load_data     = 32'h0;

        test_reset();
        test_load_fetch();
        test_fwd();
        test_latency();
        test_illegal();
        test_reset_mid();
        test_load_priority();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
